// File: rtl/jtframe_eeprom93.sv
// Microwire serial EEPROM model (93C46/56/66 class) driven by CPU bit-banged latches,
// with a second RAM port used to dump and restore the contents.
module jtframe_eeprom93 #(
   parameter int unsigned   DW   = 16,
   parameter int unsigned   AW   = 6,
   parameter int unsigned   BUSY = 480,
   parameter logic [DW-1:0] INIT = {DW{1'b1}}
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          scs,
   input  logic          sclk,
   input  logic          sdi,
   output logic          sdo,
   input  logic [AW-1:0] dump_addr,
   input  logic          dump_we,
   input  logic [DW-1:0] dump_din,
   output logic [DW-1:0] dump_dout,
   output logic          dirty
);

   localparam int unsigned BCW    = $clog2(BUSY + 1);
   localparam logic [4:0]  CNT_AW = 5'(AW - 1);
   localparam logic [4:0]  CNT_DW = 5'(DW - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_OP, S_ADDR, S_RD, S_WR, S_HOLD, S_BUSY
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_sclk_l;
   logic [1:0]      r_op;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_shift;
   logic [4:0]      r_cnt;
   logic            r_we, r_pend, r_all, r_erase, r_sdo, r_dirty;
   logic [BCW-1:0]  r_busy_cnt;
   logic            r_prog_act;
   logic [AW-1:0]   r_prog_addr;

   // Power-up contents only; a dump restore loads the real data.
   logic [DW-1:0]   r_mem [0:2**AW-1] = '{default: INIT};

   logic            w_edge, w_addr_last, w_data_last, w_prog_we, w_sdo;
   logic [AW-1:0]   w_addr_nxt, w_rd_addr;
   logic [DW-1:0]   w_rd_word, w_prog_data;

   assign w_edge      = scs & sclk & ~r_sclk_l;
   assign w_addr_nxt  = {r_addr[AW-2:0], sdi};
   assign w_addr_last = (r_cnt == CNT_AW);
   assign w_data_last = (r_cnt == CNT_DW);
   assign w_rd_addr   = (r_state == S_ADDR) ? w_addr_nxt : r_addr + AW'(1);
   assign w_rd_word   = r_mem[w_rd_addr];
   assign w_prog_we   = !rst && (r_state == S_BUSY) && r_prog_act;
   assign w_prog_data = r_erase ? {DW{1'b1}} : r_shift;
   assign sdo         = w_sdo;
   assign dirty       = r_dirty;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sdo       = 1'b1;
      case (r_state)
         S_IDLE: if (w_edge && sdi) w_state_nxt = S_OP;
         S_OP: begin
            if (!scs)                           w_state_nxt = S_IDLE;
            else if (w_edge && r_cnt == 5'd1)   w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (!scs) w_state_nxt = S_IDLE;
            else if (w_edge && w_addr_last) begin
               case (r_op)
                  2'b10:   w_state_nxt = S_RD;
                  2'b01:   w_state_nxt = S_WR;
                  2'b11:   w_state_nxt = S_HOLD;
                  default: w_state_nxt = (w_addr_nxt[AW-1:AW-2] == 2'b01) ? S_WR : S_HOLD;
               endcase
            end
         end
         S_RD: begin
            w_sdo = r_sdo;
            if (!scs) w_state_nxt = S_IDLE;
         end
         S_WR: begin
            if (!scs)                          w_state_nxt = S_IDLE;
            else if (w_edge && w_data_last)    w_state_nxt = S_HOLD;
         end
         S_HOLD: if (!scs) w_state_nxt = (r_pend && r_we) ? S_BUSY : S_IDLE;
         S_BUSY: begin
            // Ready only once the timer has run out and any sweep has finished.
            w_sdo = !scs || (r_busy_cnt == '0 && !r_prog_act);
            if (!scs && r_busy_cnt == '0 && !r_prog_act) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_l    <= 1'b0;
         r_op        <= 2'b00;
         r_addr      <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_pend      <= 1'b0;
         r_all       <= 1'b0;
         r_erase     <= 1'b0;
         r_sdo       <= 1'b1;
         r_dirty     <= 1'b0;
         r_busy_cnt  <= '0;
         r_prog_act  <= 1'b0;
         r_prog_addr <= '0;
      end else begin
         r_sclk_l <= sclk;
         if (dump_we) r_dirty <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt  <= '0;
               r_pend <= 1'b0;
            end
            S_OP: if (w_edge) begin
               r_op  <= {r_op[0], sdi};
               r_cnt <= (r_cnt == 5'd1) ? 5'd0 : r_cnt + 5'd1;
            end
            S_ADDR: if (w_edge) begin
               r_addr <= w_addr_nxt;
               r_cnt  <= r_cnt + 5'd1;
               if (w_addr_last) begin
                  r_cnt   <= '0;
                  r_all   <= 1'b0;
                  r_erase <= 1'b0;
                  r_pend  <= 1'b0;
                  case (r_op)
                     2'b10: begin
                        r_shift <= w_rd_word;
                        r_sdo   <= 1'b0;
                     end
                     2'b01: ;
                     2'b11: begin
                        r_pend  <= 1'b1;
                        r_erase <= 1'b1;
                     end
                     default: begin
                        case (w_addr_nxt[AW-1:AW-2])
                           2'b11: r_we <= 1'b1;
                           2'b00: r_we <= 1'b0;
                           2'b10: begin
                              r_pend  <= 1'b1;
                              r_erase <= 1'b1;
                              r_all   <= 1'b1;
                           end
                           default: r_all <= 1'b1;
                        endcase
                     end
                  endcase
               end
            end
            S_RD: if (w_edge) begin
               r_sdo <= r_shift[DW-1];
               if (w_data_last) begin
                  r_cnt   <= '0;
                  r_addr  <= r_addr + AW'(1);
                  r_shift <= w_rd_word;
               end else begin
                  r_cnt   <= r_cnt + 5'd1;
                  r_shift <= {r_shift[DW-2:0], 1'b0};
               end
            end
            S_WR: if (w_edge) begin
               r_shift <= {r_shift[DW-2:0], sdi};
               r_cnt   <= r_cnt + 5'd1;
               if (w_data_last) r_pend <= 1'b1;
            end
            S_HOLD: if (!scs && r_pend && r_we) begin
               r_busy_cnt  <= BCW'(BUSY);
               r_prog_act  <= 1'b1;
               r_prog_addr <= r_all ? '0 : r_addr;
            end
            S_BUSY: begin
               if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - BCW'(1);
               if (r_prog_act) begin
                  r_dirty     <= 1'b1;
                  r_prog_addr <= r_prog_addr + AW'(1);
                  if (!r_all || r_prog_addr == '1) r_prog_act <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // The dump port has the last word when both ports hit the same address.
   always_ff @(posedge clk) begin
      if (w_prog_we && !(dump_we && dump_addr == r_prog_addr))
         r_mem[r_prog_addr] <= w_prog_data;
      if (dump_we)
         r_mem[dump_addr] <= dump_din;
      dump_dout <= r_mem[dump_addr];
   end

endmodule
